// File: rtl/neuron_layer_loader_if.sv
// neuron_layer_loader_if: upstream value stream and layer write port of the loader
interface neuron_layer_loader_if #(parameter int SIZE = 16);
    logic            in_valid;
    logic [SIZE-1:0] in_data;
    logic            in_ready;
    logic [SIZE-1:0] load_value;
    logic [SIZE-1:0] load_address;
    logic            load_enable;
    modport slave (
        input  in_valid, in_data,
        output in_ready, load_value, load_address, load_enable
    );
    modport master (
        output in_valid, in_data,
        input  in_ready, load_value, load_address, load_enable
    );
endinterface

// File: rtl/neuron_layer_loader.sv
// neuron_layer_loader: streams values into layer slots; NEURON_LOADER_BASE_EN adds a base_address input
module neuron_layer_loader #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SIZE-1:0]       count,
`ifdef NEURON_LOADER_BASE_EN
    input  logic [SIZE-1:0]       base_address,
`endif
    neuron_layer_loader_if.slave  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [SIZE-1:0] LS = SIZE'(LAYER_SZ);
    state_t state, next;
    logic [SIZE-1:0] base_in, room, eff, base_q, cnt_q, idx_q;
    logic clamp, beat, last;
`ifdef NEURON_LOADER_BASE_EN
    assign base_in = base_address;
`else
    assign base_in = '0;
`endif
    assign bus.in_ready = state == LOAD;
    assign busy = state != IDLE;
    assign done = state == DONE;
    // A base past the layer leaves no room, so any nonzero count is clamped to zero writes
    always_comb begin
        room = base_in >= LS ? '0 : LS - base_in;
        clamp = count > room;
        eff = clamp ? room : count;
        beat = state == LOAD && bus.in_valid;
        last = idx_q == cnt_q - SIZE'(1);
        next = state == IDLE ? (start ? (eff == '0 ? DONE : LOAD) : IDLE)
             : state == LOAD ? (beat && last ? DONE : LOAD)
             : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            base_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            overflow <= 1'b0;
            bus.load_enable <= 1'b0;
            bus.load_value <= '0;
            bus.load_address <= '0;
        end else begin
            state <= next;
            bus.load_enable <= beat;
            if (beat) begin
                bus.load_value <= bus.in_data;
                bus.load_address <= base_q + idx_q;
                idx_q <= idx_q + SIZE'(1);
            end
            if (state == IDLE && start) begin
                base_q <= base_in;
                cnt_q <= eff;
                idx_q <= '0;
                overflow <= clamp;
            end
        end
    end
endmodule

// File: tb/tb_neuron_layer_loader.sv
// tb_neuron_layer_loader: directed scenarios for neuron_layer_loader with hand-computed expectations
module tb_neuron_layer_loader;
    logic clk = 0, reset = 1, start = 0;
    logic [15:0] count = '0, base_address = '0;
    logic busy, done, overflow;
    int errors = 0, checks = 0;
    int le_n, done_n, lat_err, hold_err, first_le, last_le;
    bit done_le, rdy_seen;
    logic [15:0] done_addr;
    logic [15:0] addrs[$], vals[$];

    neuron_layer_loader_if #(.SIZE(16)) bus();

    neuron_layer_loader #(.SIZE(16), .LAYER_SZ(10)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count),
`ifdef NEURON_LOADER_BASE_EN
        .base_address(base_address),
`endif
        .bus(bus), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Starts a sequence and observes it until one cycle past done (or a 60-cycle budget)
    task automatic run_seq(input logic [15:0] cnt, input logic [15:0] base, input logic [7:0] vpat,
                           input int plen, input int stray);
        logic [15:0] d;
        bit beat_prev, fin;
        le_n = 0; done_n = 0; done_le = 0; done_addr = '0; lat_err = 0; hold_err = 0;
        rdy_seen = 0; first_le = -1; last_le = -1;
        addrs.delete(); vals.delete();
        d = 1; beat_prev = 0; fin = 0;
        start = 1; count = cnt; base_address = base; bus.in_valid = 0; bus.in_data = d;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(posedge clk); #1;
            start = (stray > 0 && c + 1 == stray);
            if (start) count = 16'd2;
            if (bus.load_enable !== beat_prev) lat_err++;
            if (bus.load_enable) begin
                le_n++;
                addrs.push_back(bus.load_address);
                vals.push_back(bus.load_value);
                if (first_le < 0) first_le = c;
                last_le = c;
            end else if (le_n > 0 && (bus.load_address !== addrs[$] || bus.load_value !== vals[$])) hold_err++;
            if (bus.in_ready) rdy_seen = 1;
            if (done_n > 0) fin = 1;
            if (done) begin
                done_n++;
                done_le = bus.load_enable;
                done_addr = bus.load_address;
            end
            bus.in_valid = vpat[c % plen];
            bus.in_data = d;
            beat_prev = bus.in_valid && bus.in_ready;
            if (beat_prev) d++;
        end
        bus.in_valid = 0;
        start = 0;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_data = '0; reset = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.load_enable !== 1'b0) begin errors++; $display("FAIL reset_load_enable got=%b exp=0", bus.load_enable); end
        checks++; if (bus.load_value !== 16'd0) begin errors++; $display("FAIL reset_load_value got=%0d exp=0", bus.load_value); end
        checks++; if (bus.load_address !== 16'd0) begin errors++; $display("FAIL reset_load_address got=%0d exp=0", bus.load_address); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        reset = 0;
    endtask

    task automatic test_full_load();
        logic [15:0] a, v;
        run_seq(16'd10, 16'd0, 8'hFF, 1, 0);
        checks++; if (le_n !== 10) begin errors++; $display("FAIL full_strobes got=%0d exp=10", le_n); end
        checks++; if (last_le - first_le !== 9) begin errors++; $display("FAIL full_consecutive got=%0d exp=9", last_le - first_le); end
        for (int i = 0; i < 10; i++) begin
            a = (i < addrs.size()) ? addrs[i] : 16'hxxxx;
            v = (i < vals.size()) ? vals[i] : 16'hxxxx;
            checks++; if (a !== 16'(i)) begin errors++; $display("FAIL full_addr[%0d] got=%0d exp=%0d", i, a, i); end
            checks++; if (v !== 16'(i + 1)) begin errors++; $display("FAIL full_value[%0d] got=%0d exp=%0d", i, v, i + 1); end
        end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL full_done_count got=%0d exp=1", done_n); end
        checks++; if (done_le !== 1'b1 || done_addr !== 16'd9) begin errors++; $display("FAIL full_done_align got le=%b addr=%0d exp le=1 addr=9", done_le, done_addr); end
        checks++; if (lat_err !== 0) begin errors++; $display("FAIL full_latency got=%0d exp=0", lat_err); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_stall();
        logic [47:0] got;
        run_seq(16'd3, 16'd0, 8'b0001_0101, 5, 0);
        got = {addrs.size() > 0 ? addrs[0] : 16'hxxxx, addrs.size() > 1 ? addrs[1] : 16'hxxxx, addrs.size() > 2 ? addrs[2] : 16'hxxxx};
        checks++; if (le_n !== 3) begin errors++; $display("FAIL stall_strobes got=%0d exp=3", le_n); end
        checks++; if (got !== {16'd0, 16'd1, 16'd2}) begin errors++; $display("FAIL stall_addrs got=%h exp=000000010002", got); end
        got = {vals.size() > 0 ? vals[0] : 16'hxxxx, vals.size() > 1 ? vals[1] : 16'hxxxx, vals.size() > 2 ? vals[2] : 16'hxxxx};
        checks++; if (got !== {16'd1, 16'd2, 16'd3}) begin errors++; $display("FAIL stall_values got=%h exp=000100020003", got); end
        checks++; if (lat_err !== 0) begin errors++; $display("FAIL stall_latency got=%0d exp=0", lat_err); end
        checks++; if (hold_err !== 0) begin errors++; $display("FAIL stall_hold got=%0d exp=0", hold_err); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL stall_done_count got=%0d exp=1", done_n); end
    endtask

    task automatic test_overflow();
        logic [15:0] a;
        run_seq(16'd15, 16'd0, 8'hFF, 1, 0);
        a = (addrs.size() > 0) ? addrs[$] : 16'hxxxx;
        checks++; if (le_n !== 10) begin errors++; $display("FAIL ovf_strobes got=%0d exp=10", le_n); end
        checks++; if (a !== 16'd9) begin errors++; $display("FAIL ovf_last_addr got=%0d exp=9", a); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        run_seq(16'd2, 16'd0, 8'hFF, 1, 0);
        checks++; if (le_n !== 2) begin errors++; $display("FAIL ovf_next_strobes got=%0d exp=2", le_n); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
    endtask

    task automatic test_zero_count();
        run_seq(16'd0, 16'd0, 8'hFF, 1, 0);
        checks++; if (done_n !== 1) begin errors++; $display("FAIL zero_done got=%0d exp=1", done_n); end
        checks++; if (le_n !== 0) begin errors++; $display("FAIL zero_strobes got=%0d exp=0", le_n); end
        checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL zero_in_ready got=%b exp=0", rdy_seen); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL zero_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] a;
        start = 1; count = 16'd8; bus.in_valid = 1; bus.in_data = 16'd1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            start = 0;
            if (bus.in_ready) bus.in_data = bus.in_data + 16'd1;
        end
        reset = 1;
        @(posedge clk); #1;
        checks++;
        if ({bus.in_ready, bus.load_enable, busy, done, overflow} !== 5'b0 || bus.load_value !== 16'd0 || bus.load_address !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy=%b le=%b busy=%b done=%b ovf=%b val=%0d addr=%0d exp all 0",
                     bus.in_ready, bus.load_enable, busy, done, overflow, bus.load_value, bus.load_address);
        end
        reset = 0; bus.in_valid = 0;
        run_seq(16'd2, 16'd0, 8'hFF, 1, 0);
        a = (addrs.size() > 0) ? addrs[0] : 16'hxxxx;
        checks++; if (a !== 16'd0) begin errors++; $display("FAIL midreset_restart_addr got=%0d exp=0", a); end
        checks++; if (le_n !== 2) begin errors++; $display("FAIL midreset_restart_strobes got=%0d exp=2", le_n); end
    endtask

`ifdef NEURON_LOADER_BASE_EN
    task automatic test_base();
        logic [47:0] got;
        run_seq(16'd5, 16'd7, 8'hFF, 1, 2);
        got = {addrs.size() > 0 ? addrs[0] : 16'hxxxx, addrs.size() > 1 ? addrs[1] : 16'hxxxx, addrs.size() > 2 ? addrs[2] : 16'hxxxx};
        checks++; if (le_n !== 3) begin errors++; $display("FAIL base_strobes got=%0d exp=3", le_n); end
        checks++; if (got !== {16'd7, 16'd8, 16'd9}) begin errors++; $display("FAIL base_addrs got=%h exp=000700080009", got); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL base_overflow got=%b exp=1", overflow); end
        checks++; if (done_n !== 1) begin errors++; $display("FAIL base_done got=%0d exp=1", done_n); end
        run_seq(16'd3, 16'd12, 8'hFF, 1, 0);
        checks++; if (le_n !== 0 || done_n !== 1) begin errors++; $display("FAIL base_past_end got le=%0d done=%0d exp le=0 done=1", le_n, done_n); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL base_past_end_overflow got=%b exp=1", overflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_stall();
        test_overflow();
        test_zero_count();
        test_reset_mid();
`ifdef NEURON_LOADER_BASE_EN
        test_base();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/neuron_layer_loader.md
NEURON_LAYER_LOADER -- requirements
Module: neuron_layer_loader

Interface
REQ-001 SHALL have parameter SIZE, default 16: data width and address width in bits.
REQ-002 SHALL have parameter LAYER_SZ, default 10: number of neuron slots in the target layer.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: begins a load sequence when sampled high in IDLE.
REQ-006 SHALL have port count, input, SIZE bits: number of values to load, sampled with start.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream value present.
REQ-008 SHALL have port in_data, input, SIZE bits: upstream value.
REQ-009 SHALL have port in_ready, output, 1 bit: loader accepts in_data this cycle.
REQ-010 SHALL have port load_value, output, SIZE bits: value written into the layer.
REQ-011 SHALL have port load_address, output, SIZE bits: slot index written.
REQ-012 SHALL have port load_enable, output, 1 bit: write strobe, one cycle per value.
REQ-013 SHALL have port busy, output, 1 bit: high in LOAD and DONE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at sequence end.
REQ-015 SHALL have port overflow, output, 1 bit: count was clamped; sticky until next accepted start.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-017 IDLE: in_ready=0, busy=0; start=1 latches count, base, and clears index; next state LOAD, or DONE when effective count is 0.
REQ-018 Effective count SHALL be min(count, LAYER_SZ - base); overflow SHALL be set when clamping occurs, otherwise cleared.
REQ-019 LOAD: in_ready=1; a beat transfers when in_valid and in_ready are both 1.
REQ-020 On each beat, the next cycle SHALL have load_enable=1, load_value=in_data, and load_address=base+index; index then increments.
REQ-021 Latency from beat to load_enable SHALL be exactly 1 cycle; load_enable=0 in any cycle not following a beat.
REQ-022 load_value and load_address SHALL hold their last values while load_enable=0.
REQ-023 On the beat where index reaches effective count - 1, in_ready SHALL drop the next cycle and the state SHALL become DONE.
REQ-024 DONE: done=1 for exactly one cycle, coinciding with the final load_enable; next state IDLE.
REQ-025 When effective count is 0, DONE SHALL pulse done with no load_enable.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 in_valid=0 in LOAD SHALL stall with no timeout; index and address are unchanged.
REQ-028 Address arithmetic SHALL be SIZE bits unsigned; base+index never exceeds LAYER_SZ-1, by the clamp.

Reset
REQ-029 reset=1 SHALL force IDLE at the next edge, including mid-sequence, discarding progress with no done pulse.
REQ-030 Reset values SHALL be: in_ready=0, load_enable=0, load_value=0, load_address=0, busy=0, done=0, overflow=0, index=0, base=0.

Configuration
REQ-031 Macro NEURON_LOADER_BASE_EN defined SHALL add input base_address, SIZE bits, sampled with start as base; base_address >= LAYER_SZ SHALL give effective count 0 and overflow=1 when count>0.
REQ-032 Without NEURON_LOADER_BASE_EN, port base_address SHALL be absent and base SHALL be 0.

Verification
REQ-033 Reset then start with count=10, in_valid held 1, data 1..10 -> load_enable high 10 consecutive cycles, addresses 0..9, values 1..10, done coincident with address 9, overflow=0.
REQ-034 count=3, in_valid toggling 1,0,1,0,1 -> exactly 3 strobes at addresses 0,1,2, each one cycle after its beat, done once.
REQ-035 count=15 -> 10 writes at addresses 0..9, overflow=1; a following start with count=2 -> overflow=0.
REQ-036 count=0 -> done pulses without load_enable; in_ready stays 0.
REQ-037 reset asserted after 4 beats of count=8 -> next cycle all outputs at reset values, no done; a new start loads from address 0.
REQ-038 With NEURON_LOADER_BASE_EN, base_address=7 and count=5 -> addresses 7,8,9, overflow=1; start pulsed during LOAD is ignored.
